// File: rtl/fpu_op_sequencer_pkg.sv
// Shared constants for the 8-bit FPU front end: opcodes, special values,
// exception codes and the issue-stage FSM encoding.
package fpu_op_sequencer_pkg;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_SUB     = 2'b01;
    localparam logic [1:0] OP_MUL     = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    // 1-4-3 format: exponent all ones with zero mantissa is infinity
    localparam logic [7:0] PLUS_INF  = 8'h78;
    localparam logic [7:0] MINUS_INF = 8'hF8;
    localparam logic [7:0] CANON_NAN = 8'h7C;

    localparam logic [1:0] EXCE_NONE      = 2'b00;
    localparam logic [1:0] EXCE_INVALID   = 2'b01;
    localparam logic [1:0] EXCE_OVERFLOW  = 2'b10;
    localparam logic [1:0] EXCE_UNDERFLOW = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] exce;
        logic       timeout;
    } fpu_resp_t;

endpackage

// File: rtl/fpu_op_sequencer_if.sv
// Bundle of request, checker/core and response signals around the issue stage.
// The slave modport is the sequencer's view; master is its environment.
interface fpu_op_sequencer_if;

    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;

    logic [1:0] fp_operation;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       op_is_exception;

    logic       core_start;
    logic       core_done;
    logic [7:0] core_result;
    logic [1:0] core_exce;

    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [1:0] fp_exce;
    logic       res_timeout;

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        input  op_is_exception,
        input  core_done, core_result, core_exce,
        input  res_ready,
        output req_ready, fp_operation, op_a, op_b,
        output core_start,
        output res_valid, res_data, fp_exce, res_timeout
    );

    modport master (
        output req_valid, req_op, req_a, req_b,
        output op_is_exception,
        output core_done, core_result, core_exce,
        output res_ready,
        input  req_ready, fp_operation, op_a, op_b,
        input  core_start,
        input  res_valid, res_data, fp_exce, res_timeout
    );

endinterface

// File: rtl/fpu_op_sequencer.sv
// FPU issue stage: latches one operation, bypasses the core with a NaN on a
// checker exception, otherwise runs the core under a timeout and returns a result.
module fpu_op_sequencer
    import fpu_op_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input logic               clk,
    input logic               rst,
    fpu_op_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] CntLimit = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q;
    logic [7:0]       a_q, b_q;
    fpu_resp_t        resp_q, resp_d;
    logic             accept;
    logic             bypass;

    assign accept = (state_q == ST_IDLE) && bus.req_valid;
    assign bypass = bus.op_is_exception || (op_q == OP_ILLEGAL);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (bypass) begin
                    resp_d  = '{data: CANON_NAN, exce: EXCE_INVALID, timeout: 1'b0};
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // done takes priority over a timeout landing in the same cycle
                if (bus.core_done) begin
                    resp_d  = '{data: bus.core_result, exce: bus.core_exce, timeout: 1'b0};
                    state_d = ST_RESP;
                end else if (cnt_q == CntLimit) begin
                    resp_d  = '{data: CANON_NAN, exce: EXCE_INVALID, timeout: 1'b1};
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            if (accept) begin
                op_q <= bus.req_op;
                a_q  <= bus.req_a;
                b_q  <= bus.req_b;
            end
        end
    end

    assign bus.req_ready    = (state_q == ST_IDLE);
    assign bus.fp_operation = op_q;
    assign bus.op_a         = a_q;
    assign bus.op_b         = b_q;
    assign bus.core_start   = (state_q == ST_CHECK) && !bypass;
    assign bus.res_valid    = (state_q == ST_RESP);
    assign bus.res_data     = resp_q.data;
    assign bus.fp_exce      = resp_q.exce;
    assign bus.res_timeout  = resp_q.timeout;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Randomized bench for fpu_op_sequencer: a transaction-level model predicts the
// busy window, start pulse and response of each request; outputs are compared every cycle.
module tb_fpu_op_sequencer;
    import fpu_op_sequencer_pkg::*;

    localparam int TO    = 16;
    localparam int NEVER = 100000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    fpu_op_sequencer_if bus ();

    fpu_op_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    function automatic logic is_inf(input logic [7:0] v);
        return v[6:0] == 7'h78;
    endfunction
    function automatic logic is_nan(input logic [7:0] v);
        return (v[6:3] == 4'hF) && (v[2:0] != 3'd0);
    endfunction
    function automatic logic is_zero(input logic [7:0] v);
        return v[6:0] == 7'h00;
    endfunction

    // Stand-in exception checker: NaN inputs and the invalid IEEE cases
    function automatic logic exc_of(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic both_inf;
        both_inf = is_inf(a) && is_inf(b);
        return is_nan(a) || is_nan(b)
            || (op == OP_ADD && both_inf && (a[7] != b[7]))
            || (op == OP_SUB && both_inf && (a[7] == b[7]))
            || (op == OP_MUL && ((is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))));
    endfunction

    assign bus.op_is_exception = exc_of(bus.fp_operation, bus.op_a, bus.op_b);

    // Model of the transaction in flight: busy over [m_acc, m_hs), valid over [m_resp, m_hs)
    int         m_acc  = -1;
    int         m_resp = NEVER;
    int         m_hs   = 0;
    logic       m_byp  = 1'b0;
    logic [1:0] m_op   = '0;
    logic [7:0] m_a    = '0;
    logic [7:0] m_b    = '0;
    logic [7:0] m_data = '0;
    logic [1:0] m_exce = '0;
    logic       m_to   = 1'b0;
    bit         chk_en = 1'b0;

    logic [7:0] cap_data;
    logic [1:0] cap_exce;
    logic       cap_to;
    int         cap_first;
    int         cap_vcnt;
    int         start_cnt = 0;

    int   c;
    bit   busy, exp_v, exp_s;
    logic prev_v = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                c     = cyc;
                busy  = (c >= m_acc) && (c < m_hs);
                exp_v = busy && (c >= m_resp);
                exp_s = busy && (c == m_acc) && !m_byp;
                chk("req_ready", 32'(bus.req_ready), 32'(!busy));
                chk("res_valid", 32'(bus.res_valid), 32'(exp_v));
                chk("core_start", 32'(bus.core_start), 32'(exp_s));
                chk("fp_operation", 32'(bus.fp_operation), 32'(m_op));
                chk("op_a", 32'(bus.op_a), 32'(m_a));
                chk("op_b", 32'(bus.op_b), 32'(m_b));
                if (exp_v) begin
                    chk("res_data", 32'(bus.res_data), 32'(m_data));
                    chk("fp_exce", 32'(bus.fp_exce), 32'(m_exce));
                    chk("res_timeout", 32'(bus.res_timeout), 32'(m_to));
                end
                if (bus.res_valid) begin
                    if (!prev_v) cap_first = c;
                    cap_vcnt++;
                    cap_data = bus.res_data;
                    cap_exce = bus.fp_exce;
                    cap_to   = bus.res_timeout;
                end
                if (bus.core_start) start_cnt++;
                prev_v = bus.res_valid;
            end
        end
    end

    // One request from acceptance to handshake (or to a reset pulse rst_at edges after accept).
    // Called #1 after an edge with the sequencer idle for the coming cycle.
    task automatic run_txn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           input int d, input logic [7:0] cres, input logic [1:0] cexc,
                           input int hold, input int rst_at);
        int s;
        int hs;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk);
        #1;
        m_acc  = cyc;
        s      = m_acc + 1;
        m_byp  = exc_of(op, a, b) || (op == OP_ILLEGAL);
        if (m_byp) begin
            m_resp = s;
            m_data = CANON_NAN; m_exce = EXCE_INVALID; m_to = 1'b0;
        end else if (d <= TO) begin
            m_resp = s + d;
            m_data = cres; m_exce = cexc; m_to = 1'b0;
        end else begin
            m_resp = s + TO;
            m_data = CANON_NAN; m_exce = EXCE_INVALID; m_to = 1'b1;
        end
        hs = m_resp + hold + 1;
        if (rst_at > 0 && m_acc + rst_at < hs) hs = m_acc + rst_at;
        m_hs = hs;
        m_op = op; m_a = a; m_b = b;
        // inputs for the cycle sampled at edge e+1; busy-time requests are noise
        for (int e = m_acc; e < m_hs; e++) begin
            bus.core_done   = !m_byp && (d != NEVER) && (e + 1 == s + d);
            bus.core_result = bus.core_done ? cres : 8'($urandom);
            bus.core_exce   = bus.core_done ? cexc : 2'($urandom);
            bus.res_ready   = (e + 1 == m_resp + hold + 1)
                           || ((e + 1 <= m_resp) && ($urandom_range(0, 1) == 1));
            rst             = (rst_at > 0) && (e + 1 == m_hs);
            bus.req_valid   = 1'($urandom);
            bus.req_op      = 2'($urandom);
            bus.req_a       = 8'($urandom);
            bus.req_b       = 8'($urandom);
            @(posedge clk);
            #1;
        end
        bus.core_done = 1'b0;
        bus.res_ready = 1'b0;
        bus.req_valid = 1'b0;
        if (rst) begin
            rst  = 1'b0;
            m_op = '0; m_a = '0; m_b = '0;
        end
    endtask

    function automatic logic [7:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return PLUS_INF;
            1:       return MINUS_INF;
            2:       return 8'h00;
            3:       return CANON_NAN;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int s0;
    int dd;
    int ra;

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_op      = '0;
        bus.req_a       = '0;
        bus.req_b       = '0;
        bus.core_done   = 1'b0;
        bus.core_result = '0;
        bus.core_exce   = '0;
        bus.res_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_core_start", 32'(bus.core_start), 32'd0);
        chk("rst_res_data", 32'(bus.res_data), 32'd0);
        chk("rst_fp_exce", 32'(bus.fp_exce), 32'd0);
        @(posedge clk);
        #1;

        // ADD through the core, done 3 cycles after start
        s0 = start_cnt; cap_vcnt = 0;
        run_txn(OP_ADD, 8'h30, 8'h28, 3, 8'h38, EXCE_NONE, 0, 0);
        chk("add_data", 32'(cap_data), 32'h38);
        chk("add_exce", 32'(cap_exce), 32'd0);
        chk("add_timeout", 32'(cap_to), 32'd0);
        chk("add_starts", 32'(start_cnt - s0), 32'd1);
        chk("add_latency", 32'(cap_first - m_acc), 32'd4);

        // +inf + -inf is flagged by the checker: bypass
        s0 = start_cnt;
        run_txn(OP_ADD, PLUS_INF, MINUS_INF, 3, 8'h11, EXCE_NONE, 0, 0);
        chk("inf_data", 32'(cap_data), 32'h7C);
        chk("inf_exce", 32'(cap_exce), 32'd1);
        chk("inf_starts", 32'(start_cnt - s0), 32'd0);
        chk("inf_latency", 32'(cap_first - m_acc), 32'd1);

        // illegal opcode
        s0 = start_cnt;
        run_txn(OP_ILLEGAL, 8'h12, 8'h34, 2, 8'h55, EXCE_NONE, 0, 0);
        chk("ill_data", 32'(cap_data), 32'h7C);
        chk("ill_exce", 32'(cap_exce), 32'd1);
        chk("ill_starts", 32'(start_cnt - s0), 32'd0);

        // MUL timeout with a late done pulse arriving in RESP
        run_txn(OP_MUL, 8'h30, 8'h38, TO + 1, 8'h99, EXCE_OVERFLOW, 2, 0);
        chk("to_data", 32'(cap_data), 32'h7C);
        chk("to_exce", 32'(cap_exce), 32'd1);
        chk("to_flag", 32'(cap_to), 32'd1);
        chk("to_latency", 32'(cap_first - m_acc), 32'd17);

        // done on the last allowed cycle wins over the timeout
        run_txn(OP_SUB, 8'h40, 8'h20, TO, 8'h5A, EXCE_UNDERFLOW, 0, 0);
        chk("edge_data", 32'(cap_data), 32'h5A);
        chk("edge_flag", 32'(cap_to), 32'd0);

        // consumer holds off 5 cycles
        cap_vcnt = 0;
        run_txn(OP_SUB, 8'h38, 8'h30, 2, 8'h28, EXCE_NONE, 5, 0);
        chk("hold_valid_cycles", 32'(cap_vcnt), 32'd6);
        chk("hold_data", 32'(cap_data), 32'h28);

        // reset pulsed during RUN, then a normal request
        run_txn(OP_MUL, 8'h30, 8'h38, NEVER, 8'h00, EXCE_NONE, 0, 6);
        @(negedge clk);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
        @(posedge clk);
        #1;
        run_txn(OP_ADD, 8'h30, 8'h30, 1, 8'h38, EXCE_NONE, 0, 0);
        chk("post_rst_data", 32'(cap_data), 32'h38);

        for (int i = 0; i < 150; i++) begin
            dd = $urandom_range(1, TO + 2);
            if (dd == TO + 2) dd = NEVER;
            ra = ($urandom_range(0, 9) == 0) ? $urandom_range(1, TO + 8) : 0;
            run_txn(2'($urandom), rand_opnd(), rand_opnd(), dd, 8'($urandom), 2'($urandom),
                    $urandom_range(0, 4), ra);
        end

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
